usbfs_serial_chan_mux: RTL and testbench

Multiplexes N logical byte channels onto the single bulk byte-stream pair exported by the USB full-speed serial device. Sits between the serial device's devToHost/hostToDev valid/ready byte ports and N independent user channels. Transmit bytes are buffered per channel, arbitrated round-robin and framed with a one-byte header. Receive frames are parsed and demultiplexed to the addressed channel with per-channel backpressure.

---
 rtl/usbfs_serial_chan_mux.sv | 227 ++++++++++++++++++++++
 tb/tb_usbfs_serial_chan_mux.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usbfs_serial_chan_mux.sv
// Framed N-channel byte mux over the USB-FS serial device byte streams.
// Optional receive error counter: define USBFS_SERIAL_CHAN_MUX_ERRCNT_EN.
module usbfs_serial_chan_mux #(
  parameter int N_CHAN     = 4,
  parameter int MAX_BURST  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_devToHost_valid,
  output logic [7:0]            o_devToHost_data,
  input  logic                  i_devToHost_ready,
  input  logic                  i_hostToDev_valid,
  input  logic [7:0]            i_hostToDev_data,
  output logic                  o_hostToDev_ready,
  input  logic [N_CHAN-1:0]     i_tx_valid,
  input  logic [8*N_CHAN-1:0]   i_tx_data,
  output logic [N_CHAN-1:0]     o_tx_ready,
  output logic [N_CHAN-1:0]     o_rx_valid,
  output logic [8*N_CHAN-1:0]   o_rx_data,
  input  logic [N_CHAN-1:0]     i_rx_ready,
  output logic [7:0]            o_rxErrCnt
);
  // state      | meaning
  // TX_IDLE    | pick next non-empty channel round-robin from rr_q
  // TX_HDR     | present {chan, cnt} header
  // TX_PAY     | stream cnt bytes from the granted FIFO
  // RX_HDR     | accept and decode a header
  // RX_PAY     | pass payload straight through to the addressed channel
  // RX_DISCARD | swallow payload addressed to a nonexistent channel
  localparam int CW = $clog2(N_CHAN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0] NCH4 = 4'(N_CHAN);

  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_PAY} tx_state_e;
  typedef enum logic [1:0] {RX_HDR, RX_PAY, RX_DISCARD} rx_state_e;

  logic [7:0]        mem_q    [N_CHAN][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q [N_CHAN];
  logic [AW-1:0]     rd_ptr_q [N_CHAN];
  logic [OW-1:0]     occ_q    [N_CHAN];
  logic [OW-1:0]     occ_d    [N_CHAN];
  logic [N_CHAN-1:0] tx_rdy_q, wr_en, pop_en;

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] chan_q, chan_d, rr_q, rr_d, grant_idx;
  logic [3:0]    cnt_q, cnt_d, grant_cnt;
  logic          grant_vld;
  int            idx;

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_chan_q, rx_chan_d;
  logic [3:0]    rem_q, rem_d;
  logic          h2d_ready, h2d_acc;
  logic [3:0]    hdr_chan, hdr_len;

  // ---------------- transmit FIFOs ----------------
  always_comb begin
    wr_en  = i_tx_valid & tx_rdy_q;
    pop_en = '0;
    if (tx_state_q == TX_PAY && i_devToHost_ready) pop_en[chan_q] = 1'b1;
    for (int c = 0; c < N_CHAN; c++)
      occ_d[c] = occ_q[c] + OW'(wr_en[c]) - OW'(pop_en[c]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < N_CHAN; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        occ_q[c]    <= '0;
      end
      tx_rdy_q <= '1;
    end else begin
      for (int c = 0; c < N_CHAN; c++) begin
        if (wr_en[c])  wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
        if (pop_en[c]) rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
        occ_q[c]    <= occ_d[c];
        tx_rdy_q[c] <= (occ_d[c] != OW'(FIFO_DEPTH));
      end
    end
  end

  // Storage needs no reset: emptiness is tracked by occ_q alone.
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < N_CHAN; c++)
      if (wr_en[c]) mem_q[c][wr_ptr_q[c]] <= i_tx_data[8*c +: 8];
  end

  assign o_tx_ready = tx_rdy_q;

  // ---------------- transmit FSM ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state_q <= TX_IDLE;
      chan_q     <= '0;
      cnt_q      <= '0;
      rr_q       <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      chan_q     <= chan_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 0; i < N_CHAN; i++) begin
      idx = (int'(rr_q) + i) % N_CHAN;
      if (!grant_vld && occ_q[idx] != '0) begin
        grant_vld = 1'b1;
        grant_idx = CW'(idx);
      end
    end
    grant_cnt = (int'(occ_q[grant_idx]) > MAX_BURST) ? 4'(MAX_BURST) : 4'(occ_q[grant_idx]);

    tx_state_d = tx_state_q;
    chan_d     = chan_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    case (tx_state_q)
      TX_IDLE: if (grant_vld) begin
        tx_state_d = TX_HDR;
        chan_d     = grant_idx;
        cnt_d      = grant_cnt;
      end
      TX_HDR: if (i_devToHost_ready) tx_state_d = TX_PAY;
      TX_PAY: if (i_devToHost_ready) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 4'd1) begin
          tx_state_d = TX_IDLE;
          rr_d       = (chan_q == CW'(N_CHAN - 1)) ? '0 : chan_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    o_devToHost_valid = 1'b0;
    o_devToHost_data  = 8'h00;
    case (tx_state_q)
      TX_HDR: begin
        o_devToHost_valid = 1'b1;
        o_devToHost_data  = {4'(chan_q), cnt_q};
      end
      TX_PAY: begin
        o_devToHost_valid = 1'b1;
        o_devToHost_data  = mem_q[chan_q][rd_ptr_q[chan_q]];
      end
      default: ;
    endcase
  end

  // ---------------- receive FSM ----------------
  assign hdr_chan = i_hostToDev_data[7:4];
  assign hdr_len  = i_hostToDev_data[3:0];
  assign h2d_acc  = i_hostToDev_valid & h2d_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state_q <= RX_HDR;
      rx_chan_q  <= '0;
      rem_q      <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_chan_q  <= rx_chan_d;
      rem_q      <= rem_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_chan_d  = rx_chan_q;
    rem_d      = rem_q;
    case (rx_state_q)
      RX_HDR: if (h2d_acc && hdr_len != 4'd0) begin
        rem_d = hdr_len;
        if (hdr_chan >= NCH4) begin
          rx_state_d = RX_DISCARD;
        end else begin
          rx_state_d = RX_PAY;
          rx_chan_d  = hdr_chan[CW-1:0];
        end
      end
      RX_PAY, RX_DISCARD: if (h2d_acc) begin
        rem_d = rem_q - 1'b1;
        if (rem_q == 4'd1) rx_state_d = RX_HDR;
      end
      default: rx_state_d = RX_HDR;
    endcase
  end

  always_comb begin
    h2d_ready  = 1'b1;
    o_rx_valid = '0;
    o_rx_data  = '0;
    if (rx_state_q == RX_PAY) begin
      h2d_ready                          = i_rx_ready[rx_chan_q];
      o_rx_valid[rx_chan_q]              = i_hostToDev_valid;
      o_rx_data[8*int'(rx_chan_q) +: 8] = i_hostToDev_data;
    end
  end

  assign o_hostToDev_ready = h2d_ready;

`ifdef USBFS_SERIAL_CHAN_MUX_ERRCNT_EN
  logic       hdr_err;
  logic [7:0] err_cnt_q;

  assign hdr_err = (rx_state_q == RX_HDR) && h2d_acc && (hdr_len == 4'd0 || hdr_chan >= NCH4);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        err_cnt_q <= 8'h00;
    else if (hdr_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'h01;
  end

  assign o_rxErrCnt = err_cnt_q;
`else
  assign o_rxErrCnt = 8'h00;
`endif

endmodule

// File: tb/tb_usbfs_serial_chan_mux.sv
// Directed bench for usbfs_serial_chan_mux (N_CHAN=4, MAX_BURST=8, FIFO_DEPTH=16).
module tb_usbfs_serial_chan_mux;
`ifdef USBFS_SERIAL_CHAN_MUX_ERRCNT_EN
  localparam logic [7:0] EXP_ERR = 8'd2;
`else
  localparam logic [7:0] EXP_ERR = 8'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv, dr, hv, hr;
  logic [7:0]  dd, hd, errc;
  logic [3:0]  txv, txr, rxv, rxr;
  logic [31:0] txd, rxd;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [7:0] q_byte[$];
  int         q_cyc[$];

  usbfs_serial_chan_mux #(.N_CHAN(4), .MAX_BURST(8), .FIFO_DEPTH(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_devToHost_valid(dv), .o_devToHost_data(dd), .i_devToHost_ready(dr),
    .i_hostToDev_valid(hv), .i_hostToDev_data(hd), .o_hostToDev_ready(hr),
    .i_tx_valid(txv), .i_tx_data(txd), .o_tx_ready(txr),
    .o_rx_valid(rxv), .o_rx_data(rxd), .i_rx_ready(rxr),
    .o_rxErrCnt(errc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every byte the serial device takes, with the cycle it was taken.
  always @(negedge clk) begin
    if (rst_n && dv && dr) begin
      q_byte.push_back(dd);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0; dr = 1'b0; hv = 1'b0; hd = 8'h00;
    txv = '0; txd = '0; rxr = '1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    q_byte.delete();
    q_cyc.delete();
  endtask

  task automatic tx_write(input int ch, input logic [7:0] b);
    txv[ch] = 1'b1;
    txd[8*ch +: 8] = b;
    @(posedge clk); #1;
    txv[ch] = 1'b0;
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    int k = 0;
    while (q_byte.size() < n && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (q_byte.size() >= n);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (dv !== 1'b0)   $display("FAIL reset_dv: got %b want 0", dv); else n_pass++;
    n_checks++; if (dd !== 8'h00)  $display("FAIL reset_dd: got %h want 00", dd); else n_pass++;
    n_checks++; if (hr !== 1'b1)   $display("FAIL reset_hr: got %b want 1", hr); else n_pass++;
    n_checks++; if (txr !== 4'hF)  $display("FAIL reset_txr: got %h want f", txr); else n_pass++;
    n_checks++; if (rxv !== 4'h0)  $display("FAIL reset_rxv: got %h want 0", rxv); else n_pass++;
    n_checks++; if (errc !== 8'h0) $display("FAIL reset_err: got %h want 00", errc); else n_pass++;
  endtask

  task automatic test_tx_latency();
    int k;
    bit ok;
    do_reset();
    dr = 1'b1;
    k = cyc;
    tx_write(2, 8'h11);
    wait_bytes(2, ok);
    n_checks++; if (!ok) $display("FAIL lat_timeout: got %0d bytes want 2", q_byte.size()); else n_pass++;
    if (ok) begin
      n_checks++; if (q_byte[0] !== 8'h21) $display("FAIL lat_hdr: got %h want 21", q_byte[0]); else n_pass++;
      n_checks++; if (q_cyc[0] !== k + 2)  $display("FAIL lat_hdr_cyc: got %0d want %0d", q_cyc[0], k + 2); else n_pass++;
      n_checks++; if (q_byte[1] !== 8'h11) $display("FAIL lat_pay: got %h want 11", q_byte[1]); else n_pass++;
      n_checks++; if (q_cyc[1] !== k + 3)  $display("FAIL lat_pay_cyc: got %0d want %0d", q_cyc[1], k + 3); else n_pass++;
    end
  endtask

  // ch0 holds the link (device not ready) while three ch2 bytes queue up.
  task automatic test_tx_three();
    logic [7:0] exp[$];
    int bad;
    bit ok;
    do_reset();
    tx_write(0, 8'h5C);
    repeat (2) @(posedge clk); #1;
    tx_write(2, 8'h11); tx_write(2, 8'h22); tx_write(2, 8'h33);
    dr = 1'b1;
    wait_bytes(6, ok);
    repeat (5) @(posedge clk); #1;
    exp = '{8'h01, 8'h5C, 8'h23, 8'h11, 8'h22, 8'h33};
    bad = (q_byte.size() != exp.size()) ? 99 : -1;
    for (int i = 0; i < exp.size() && i < q_byte.size(); i++)
      if (bad < 0 && q_byte[i] !== exp[i]) bad = i;
    n_checks++; if (bad >= 0) $display("FAIL three_stream: len %0d mismatch at %0d, want len %0d", q_byte.size(), bad, exp.size()); else n_pass++;
    if (q_cyc.size() >= 3) begin
      n_checks++; if (q_cyc[2] - q_cyc[1] !== 2) $display("FAIL three_gap: got %0d want 2", q_cyc[2] - q_cyc[1]); else n_pass++;
    end
  endtask

  task automatic test_burst_split();
    logic [7:0] exp[$];
    int bad;
    bit ok;
    do_reset();
    tx_write(1, 8'h5C);
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 12; i++) tx_write(0, 8'hA0 + 8'(i));
    n_checks++; if (txr[0] !== 1'b1) $display("FAIL split_txr: got %b want 1", txr[0]); else n_pass++;
    dr = 1'b1;
    wait_bytes(16, ok);
    repeat (5) @(posedge clk); #1;
    exp = '{8'h11, 8'h5C, 8'h08};
    for (int i = 0; i < 8; i++) exp.push_back(8'hA0 + 8'(i));
    exp.push_back(8'h04);
    for (int i = 8; i < 12; i++) exp.push_back(8'hA0 + 8'(i));
    bad = (q_byte.size() != exp.size()) ? 99 : -1;
    for (int i = 0; i < exp.size() && i < q_byte.size(); i++)
      if (bad < 0 && q_byte[i] !== exp[i]) bad = i;
    n_checks++; if (bad >= 0) $display("FAIL split_stream: len %0d mismatch at %0d, want len %0d", q_byte.size(), bad, exp.size()); else n_pass++;
  endtask

  task automatic test_full();
    logic [7:0] exp[$];
    int bad;
    bit ok;
    do_reset();
    tx_write(1, 8'h5C);
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 15; i++) tx_write(0, 8'hB0 + 8'(i));
    n_checks++; if (txr[0] !== 1'b1) $display("FAIL full15_txr: got %b want 1", txr[0]); else n_pass++;
    tx_write(0, 8'hBF);
    n_checks++; if (txr[0] !== 1'b0) $display("FAIL full16_txr: got %b want 0", txr[0]); else n_pass++;
    tx_write(0, 8'hEE);
    n_checks++; if (txr[0] !== 1'b0) $display("FAIL full_hold_txr: got %b want 0", txr[0]); else n_pass++;
    dr = 1'b1;
    wait_bytes(4, ok);
    n_checks++; if (txr[0] !== 1'b1) $display("FAIL unfill_txr: got %b want 1", txr[0]); else n_pass++;
    wait_bytes(20, ok);
    repeat (5) @(posedge clk); #1;
    exp = '{8'h11, 8'h5C, 8'h08};
    for (int i = 0; i < 8; i++) exp.push_back(8'hB0 + 8'(i));
    exp.push_back(8'h08);
    for (int i = 8; i < 16; i++) exp.push_back(8'hB0 + 8'(i));
    bad = (q_byte.size() != exp.size()) ? 99 : -1;
    for (int i = 0; i < exp.size() && i < q_byte.size(); i++)
      if (bad < 0 && q_byte[i] !== exp[i]) bad = i;
    n_checks++; if (bad >= 0) $display("FAIL full_stream: len %0d mismatch at %0d, want len %0d", q_byte.size(), bad, exp.size()); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp[$];
    int bad;
    bit ok;
    do_reset();
    dr = 1'b1;
    txd = {8'hD3, 8'h00, 8'hD1, 8'hD0};
    txv = 4'b1011;
    @(posedge clk); #1;
    txv = '0;
    wait_bytes(6, ok);
    txd = {8'hE3, 8'h00, 8'h00, 8'hE0};
    txv = 4'b1001;
    @(posedge clk); #1;
    txv = '0;
    wait_bytes(10, ok);
    repeat (5) @(posedge clk); #1;
    exp = '{8'h01, 8'hD0, 8'h11, 8'hD1, 8'h31, 8'hD3, 8'h01, 8'hE0, 8'h31, 8'hE3};
    bad = (q_byte.size() != exp.size()) ? 99 : -1;
    for (int i = 0; i < exp.size() && i < q_byte.size(); i++)
      if (bad < 0 && q_byte[i] !== exp[i]) bad = i;
    n_checks++; if (bad >= 0) $display("FAIL rr_stream: len %0d mismatch at %0d, want len %0d", q_byte.size(), bad, exp.size()); else n_pass++;
  endtask

  task automatic test_rx_backpressure();
    do_reset();
    rxr = 4'b1101;
    hv = 1'b1; hd = 8'h12;
    #1;
    n_checks++; if (hr !== 1'b1) $display("FAIL bp_hdr_ready: got %b want 1", hr); else n_pass++;
    @(posedge clk); #1;
    hd = 8'hAA;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rxv !== 4'b0010)    $display("FAIL bp_stall_valid: cycle %0d got %b want 0010", i, rxv); else n_pass++;
      n_checks++; if (rxd[15:8] !== 8'hAA) $display("FAIL bp_stall_data: cycle %0d got %h want aa", i, rxd[15:8]); else n_pass++;
      n_checks++; if (hr !== 1'b0)        $display("FAIL bp_stall_ready: cycle %0d got %b want 0", i, hr); else n_pass++;
      @(posedge clk); #1;
    end
    rxr[1] = 1'b1;
    #1;
    n_checks++; if (hr !== 1'b1 || rxv !== 4'b0010) $display("FAIL bp_release: got ready %b valid %b want 1 0010", hr, rxv); else n_pass++;
    @(posedge clk); #1;
    hd = 8'hBB;
    #1;
    n_checks++; if (rxv !== 4'b0010) $display("FAIL bp_second_valid: got %b want 0010", rxv); else n_pass++;
    n_checks++; if (rxd !== 32'h0000BB00) $display("FAIL bp_second_data: got %h want 0000bb00", rxd); else n_pass++;
    @(posedge clk); #1;
    hv = 1'b0; rxr[1] = 1'b0;
    #1;
    n_checks++; if (hr !== 1'b1 || rxv !== 4'b0000) $display("FAIL bp_back_hdr: got ready %b valid %b want 1 0000", hr, rxv); else n_pass++;
  endtask

  task automatic test_rx_malformed();
    logic [7:0] bytes[7];
    logic [3:0] exp_v[7];
    bytes = '{8'h70, 8'h53, 8'h01, 8'h02, 8'h03, 8'h31, 8'h5A};
    exp_v = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      hv = 1'b1; hd = bytes[i];
      #1;
      n_checks++; if (hr !== 1'b1 || rxv !== exp_v[i]) $display("FAIL mal_step%0d: got ready %b valid %b want 1 %b", i, hr, rxv, exp_v[i]); else n_pass++;
      if (i == 6) begin
        n_checks++; if (rxd !== 32'h5A000000) $display("FAIL mal_data: got %h want 5a000000", rxd); else n_pass++;
      end
      @(posedge clk); #1;
    end
    hv = 1'b0; rxr = '0;
    #1;
    n_checks++; if (errc !== EXP_ERR) $display("FAIL mal_errcnt: got %0d want %0d", errc, EXP_ERR); else n_pass++;
    n_checks++; if (hr !== 1'b1) $display("FAIL mal_back_hdr: got %b want 1", hr); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    do_reset();
    rxr = 4'b1011;
    hv = 1'b1; hd = 8'h22;
    @(posedge clk); #1;
    hd = 8'h77;
    tx_write(1, 8'h5C);
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) tx_write(0, 8'hC0 + 8'(i));
    dr = 1'b1;
    wait_bytes(4, ok);
    n_checks++; if (!ok || dv !== 1'b1 || hr !== 1'b0) $display("FAIL mid_pre: got bytes %0d dv %b hr %b want 4 1 0", q_byte.size(), dv, hr); else n_pass++;
    #2;
    rst_n = 1'b0; hv = 1'b0;
    #1;
    n_checks++; if (dv !== 1'b0 || dd !== 8'h00) $display("FAIL mid_async: got dv %b dd %h want 0 00", dv, dd); else n_pass++;
    n_checks++; if (hr !== 1'b1 || txr !== 4'hF || rxv !== 4'h0) $display("FAIL mid_async_other: got hr %b txr %h rxv %h want 1 f 0", hr, txr, rxv); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    n_checks++; if (dv !== 1'b0 || q_byte.size() !== 4) $display("FAIL mid_after_tx: got dv %b bytes %0d want 0 4", dv, q_byte.size()); else n_pass++;
    n_checks++; if (hr !== 1'b1 || txr !== 4'hF || rxv !== 4'h0 || errc !== 8'h00) $display("FAIL mid_after_other: got hr %b txr %h rxv %h err %h want 1 f 0 00", hr, txr, rxv, errc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx_latency();
    test_tx_three();
    test_burst_split();
    test_full();
    test_round_robin();
    test_rx_backpressure();
    test_rx_malformed();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
